// File: rtl/hls_macc_pkg.sv
// Shared types and constants for the HLS multiply-accumulate core driver.
package hls_macc_pkg;

  localparam int unsigned MaccDw = 32;
  localparam int unsigned OpCntW = 16;
  localparam int unsigned TmoW   = 16;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StResp
  } macc_st_e;

  function automatic logic st_busy(input macc_st_e st);
    return (st == StStart) || (st == StWait);
  endfunction

endpackage

// File: rtl/hls_tmo_cnt.sv
// Operation timeout counter: counts enabled cycles from a clear and flags the
// terminal count, holding there until cleared.
module hls_tmo_cnt
  import hls_macc_pkg::*;
#(
  parameter int unsigned Limit = 1024,
  parameter int unsigned Width = TmoW
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [Width-1:0] TcVal = Width'(Limit - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TcVal);

endmodule

// File: rtl/hls_macc_drv.sv
// Host-side driver for an ap_ctrl_hs HLS MACC core: latches one operand set,
// handshakes the core, captures strobed results and aborts on timeout.
module hls_macc_drv
  import hls_macc_pkg::*;
#(
  parameter int unsigned TMO_CYC = 1024,
  parameter int unsigned DW      = MaccDw
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DW-1:0]     cmd_i1,
  input  logic [DW-1:0]     cmd_i2,
  input  logic [DW-1:0]     cmd_i3,
  input  logic [DW-1:0]     cmd_i4,
  input  logic [DW-1:0]     cmd_i6,
  output logic              core_ap_start,
  input  logic              core_ap_ready,
  input  logic              core_ap_done,
  input  logic              core_ap_idle,
  output logic [DW-1:0]     core_i1,
  output logic [DW-1:0]     core_i2,
  output logic [DW-1:0]     core_i3,
  output logic [DW-1:0]     core_i4,
  output logic [DW-1:0]     core_i6,
  input  logic [DW-1:0]     core_o1,
  input  logic [DW-1:0]     core_o2,
  input  logic              core_o1_ap_vld,
  input  logic              core_o2_ap_vld,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_o1,
  output logic [DW-1:0]     rsp_o2,
  output logic              rsp_o1_vld,
  output logic              rsp_o2_vld,
  output logic              rsp_err,
  output logic [OpCntW-1:0] op_cnt
);

  macc_st_e st_q, st_d;

  logic              start_q, start_d;
  logic [DW-1:0]     i1_q, i1_d, i2_q, i2_d, i3_q, i3_d, i4_q, i4_d, i6_q, i6_d;
  logic [DW-1:0]     o1_q, o1_d, o2_q, o2_d;
  logic              v1_q, v1_d, v2_q, v2_d;
  logic              err_q, err_d;
  logic [OpCntW-1:0] cnt_q, cnt_d;

  logic tmo_clr, tmo_en, tmo_tc;

  hls_tmo_cnt #(
    .Limit (TMO_CYC),
    .Width (TmoW)
  ) u_tmo (
    .clk_i (ap_clk),
    .rst_i (ap_rst),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .tc_o  (tmo_tc)
  );

  // Held low during reset so nothing is offered before the driver is released.
  assign cmd_ready = (st_q == StIdle) && core_ap_idle && !ap_rst;

  always_comb begin
    st_d    = st_q;
    i1_d    = i1_q;
    i2_d    = i2_q;
    i3_d    = i3_q;
    i4_d    = i4_q;
    i6_d    = i6_q;
    o1_d    = o1_q;
    o2_d    = o2_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    tmo_clr = 1'b0;
    tmo_en  = st_busy(st_q);

    // Results are only trusted while the core is running our operation.
    if (st_busy(st_q)) begin
      if (core_o1_ap_vld) begin
        o1_d = core_o1;
        v1_d = 1'b1;
      end
      if (core_o2_ap_vld) begin
        o2_d = core_o2;
        v2_d = 1'b1;
      end
    end

    unique case (st_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          i1_d    = cmd_i1;
          i2_d    = cmd_i2;
          i3_d    = cmd_i3;
          i4_d    = cmd_i4;
          i6_d    = cmd_i6;
          v1_d    = 1'b0;
          v2_d    = 1'b0;
          err_d   = 1'b0;
          tmo_clr = 1'b1;
          st_d    = StStart;
        end
      end
      StStart: begin
        if (core_ap_ready && core_ap_done) begin
          st_d = StResp;
        end else if (tmo_tc) begin
          err_d = 1'b1;
          st_d  = StResp;
        end else if (core_ap_ready) begin
          st_d = StWait;
        end
      end
      StWait: begin
        // Done on the terminal-count cycle still counts as a clean finish.
        if (core_ap_done) begin
          st_d = StResp;
        end else if (tmo_tc) begin
          err_d = 1'b1;
          st_d  = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          cnt_d = cnt_q + OpCntW'(1);
          st_d  = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase

    start_d = (st_d == StStart);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      st_q    <= StIdle;
      start_q <= 1'b0;
      i1_q    <= '0;
      i2_q    <= '0;
      i3_q    <= '0;
      i4_q    <= '0;
      i6_q    <= '0;
      o1_q    <= '0;
      o2_q    <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      start_q <= start_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      i3_q    <= i3_d;
      i4_q    <= i4_d;
      i6_q    <= i6_d;
      o1_q    <= o1_d;
      o2_q    <= o2_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign core_ap_start = start_q;
  assign core_i1       = i1_q;
  assign core_i2       = i2_q;
  assign core_i3       = i3_q;
  assign core_i4       = i4_q;
  assign core_i6       = i6_q;
  assign rsp_valid     = (st_q == StResp);
  assign rsp_o1        = o1_q;
  assign rsp_o2        = o2_q;
  assign rsp_o1_vld    = v1_q;
  assign rsp_o2_vld    = v2_q;
  assign rsp_err       = err_q;
  assign op_cnt        = cnt_q;

endmodule

// File: tb/tb_hls_macc_drv.sv
// Directed bench for hls_macc_drv: table of core behaviours plus hand-written
// hold, reset and op_cnt wrap sequences.
module tb_hls_macc_drv;

  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_i1, cmd_i2, cmd_i3, cmd_i4, cmd_i6;
  logic          core_ap_start, core_ap_ready, core_ap_done, core_ap_idle;
  logic [DW-1:0] core_i1, core_i2, core_i3, core_i4, core_i6;
  logic [DW-1:0] core_o1, core_o2;
  logic          core_o1_ap_vld, core_o2_ap_vld;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_o1, rsp_o2;
  logic          rsp_o1_vld, rsp_o2_vld, rsp_err;
  logic [15:0]   op_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cnt = '0;

  hls_macc_drv #(
    .TMO_CYC (TMO),
    .DW      (DW)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_i1         (cmd_i1),
    .cmd_i2         (cmd_i2),
    .cmd_i3         (cmd_i3),
    .cmd_i4         (cmd_i4),
    .cmd_i6         (cmd_i6),
    .core_ap_start  (core_ap_start),
    .core_ap_ready  (core_ap_ready),
    .core_ap_done   (core_ap_done),
    .core_ap_idle   (core_ap_idle),
    .core_i1        (core_i1),
    .core_i2        (core_i2),
    .core_i3        (core_i3),
    .core_i4        (core_i4),
    .core_i6        (core_i6),
    .core_o1        (core_o1),
    .core_o2        (core_o2),
    .core_o1_ap_vld (core_o1_ap_vld),
    .core_o2_ap_vld (core_o2_ap_vld),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_o1         (rsp_o1),
    .rsp_o2         (rsp_o2),
    .rsp_o1_vld     (rsp_o1_vld),
    .rsp_o2_vld     (rsp_o2_vld),
    .rsp_err        (rsp_err),
    .op_cnt         (op_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  // Cycle numbers are relative to the acceptance cycle (0); -1 means never.
  typedef struct {
    logic [31:0] i1, i2, i3, i4, i6;
    int          rdy_at;
    int          done_at;
    int          v1a_at;
    logic [31:0] o1a;
    int          v1b_at;
    logic [31:0] o1b;
    int          v2_at;
    logic [31:0] o2;
    int          exp_lat;
    logic        exp_err;
    logic        exp_v1;
    logic [31:0] exp_o1;
    logic        exp_v2;
    logic [31:0] exp_o2;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive_core(input vec_t v, input int c);
    core_ap_ready  = (c == v.rdy_at);
    core_ap_done   = (c == v.done_at);
    core_o1_ap_vld = (c == v.v1a_at) || (c == v.v1b_at);
    core_o1        = (c == v.v1b_at) ? v.o1b : (c == v.v1a_at) ? v.o1a : 32'hDEAD_BEEF;
    core_o2_ap_vld = (c == v.v2_at);
    core_o2        = (c == v.v2_at) ? v.o2 : 32'hCAFE_F00D;
  endtask

  task automatic run_vec(input vec_t v, input int hold, input string tag);
    int lat;
    cmd_i1 = v.i1;
    cmd_i2 = v.i2;
    cmd_i3 = v.i3;
    cmd_i4 = v.i4;
    cmd_i6 = v.i6;
    cmd_valid = 1'b1;
    drive_core(v, 0);
    #1;
    check({tag, " cmd_ready_idle"}, cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    cmd_i1 = 32'h0BAD_0001;
    cmd_i6 = 32'h0BAD_0006;
    check({tag, " start_c1"}, core_ap_start, 1);
    check({tag, " cmd_ready_busy"}, cmd_ready, 0);
    check({tag, " core_i1"}, core_i1, v.i1);
    check({tag, " core_i6"}, core_i6, v.i6);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      drive_core(v, c);
      step();
      if (rsp_valid) begin
        lat = c + 1;
        break;
      end
    end
    drive_core(v, -100);
    if (lat == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s rsp_valid_wait: got none within 41 cycles, want cycle %0d",
               tag, v.exp_lat);
      return;
    end
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " rsp_err"}, rsp_err, v.exp_err);
    check({tag, " rsp_o1_vld"}, rsp_o1_vld, v.exp_v1);
    check({tag, " rsp_o2_vld"}, rsp_o2_vld, v.exp_v2);
    if (v.exp_v1) check({tag, " rsp_o1"}, rsp_o1, v.exp_o1);
    if (v.exp_v2) check({tag, " rsp_o2"}, rsp_o2, v.exp_o2);
    check({tag, " start_resp"}, core_ap_start, 0);
    check({tag, " cmd_ready_resp"}, cmd_ready, 0);
    check({tag, " core_i2_resp"}, core_i2, v.i2);
    for (int h = 0; h < hold; h++) begin
      core_ap_ready  = 1'b1;
      core_ap_done   = 1'b1;
      core_o1_ap_vld = 1'b1;
      core_o1        = 32'hBAD0_0000 + h;
      step();
      check({tag, " hold_valid"}, rsp_valid, 1);
      check({tag, " hold_o1"}, rsp_o1, v.exp_o1);
      check({tag, " hold_err"}, rsp_err, v.exp_err);
      check({tag, " hold_cmd_ready"}, cmd_ready, 0);
      check({tag, " hold_start"}, core_ap_start, 0);
    end
    drive_core(v, -100);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    check({tag, " rsp_valid_done"}, rsp_valid, 0);
    check({tag, " op_cnt"}, op_cnt, exp_cnt);
    check({tag, " cmd_ready_back"}, cmd_ready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic seen;
    //               i1  i2  i3  i4  i6 rdy dn v1a o1a    v1b o1b    v2 o2     lat e  v1 eo1    v2 eo2
    tbl[0] = '{3, 4, 5, 6, 7, 2, 3, 3, 32'd17, -1, 32'd0, 3, 32'd47, 4, 0, 1, 32'd17, 1, 32'd47};
    tbl[1] = '{1, 2, 3, 4, 5, 1, 1, 1, 32'hA5, -1, 32'd0, -1, 32'd0, 2, 0, 1, 32'hA5, 0, 32'd0};
    tbl[2] = '{9, 8, 7, 6, 5, 1, 4, 2, 32'h11, 3, 32'h22, -1, 32'd0, 5, 0, 1, 32'h22, 0, 32'd0};
    tbl[3] = '{2, 2, 2, 2, 2, 2, -1, -1, 32'd0, -1, 32'd0, -1, 32'd0, 9, 1, 0, 32'd0, 0, 32'd0};
    tbl[4] = '{5, 5, 5, 5, 5, -1, -1, -1, 32'd0, -1, 32'd0, -1, 32'd0, 9, 1, 0, 32'd0, 0, 32'd0};
    tbl[5] = '{7, 1, 0, 0, 3, 2, 8, -1, 32'd0, -1, 32'd0, 8, 32'h55, 9, 0, 0, 32'd0, 1, 32'h55};
    tbl[6] = '{4, 4, 4, 4, 4, 3, 5, 0, 32'h99, -1, 32'd0, 1, 32'h77, 6, 0, 0, 32'd0, 1, 32'h77};

    ap_rst = 1'b1;
    cmd_valid = 1'b0;
    {cmd_i1, cmd_i2, cmd_i3, cmd_i4, cmd_i6} = '0;
    core_ap_idle = 1'b1;
    rsp_ready = 1'b0;
    drive_core(tbl[0], -100);
    step();
    step();
    check("rst rsp_valid", rsp_valid, 0);
    check("rst start", core_ap_start, 0);
    check("rst op_cnt", op_cnt, 0);
    check("rst core_i1", core_i1, 0);
    check("rst cmd_ready", cmd_ready, 0);
    ap_rst = 1'b0;
    step();
    check("idle cmd_ready", cmd_ready, 1);
    core_ap_idle = 1'b0;
    #1;
    check("idle cmd_ready_core_busy", cmd_ready, 0);
    core_ap_idle = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_vec(tbl[i], 0, $sformatf("vec%0d", i));

    // Response held off for 5 cycles while the core pulses done/ready/vld.
    run_vec(tbl[0], 5, "hold");

    // Reset while waiting for done abandons the operation.
    cmd_i1 = 32'h1234;
    cmd_i2 = 32'h5678;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    core_ap_ready = 1'b1;
    core_o1_ap_vld = 1'b1;
    core_o1 = 32'h3333;
    step();
    drive_core(tbl[0], -100);
    step();
    check("mid start_wait", core_ap_start, 0);
    ap_rst = 1'b1;
    step();
    check("mid rst rsp_valid", rsp_valid, 0);
    check("mid rst start", core_ap_start, 0);
    check("mid rst core_i1", core_i1, 0);
    check("mid rst rsp_o1", rsp_o1, 0);
    check("mid rst rsp_o1_vld", rsp_o1_vld, 0);
    check("mid rst op_cnt", op_cnt, 0);
    check("mid rst cmd_ready", cmd_ready, 0);
    ap_rst = 1'b0;
    exp_cnt = '0;
    step();
    check("mid rst released cmd_ready", cmd_ready, 1);
    run_vec(tbl[0], 0, "after_rst");

    // 65536 back-to-back operations with an instantly finishing core.
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    step();
    check("wrap op_cnt_start", op_cnt, 0);
    n = 0;
    seen = 1'b0;
    cmd_valid = 1'b1;
    core_ap_ready = 1'b1;
    core_ap_done = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 250000 && n < 65536; c++) begin
      if (rsp_valid) begin
        n++;
        if (n == 65536) cmd_valid = 1'b0;
      end
      step();
      if (n == 65535 && !seen) begin
        seen = 1'b1;
        check("wrap op_cnt_ffff", op_cnt, 16'hFFFF);
      end
    end
    if (n < 65536) begin
      n_tests++;
      n_fail++;
      $display("FAIL wrap ops_completed: got %0d, want 65536", n);
    end
    check("wrap op_cnt_zero", op_cnt, 0);
    check("wrap rsp_valid", rsp_valid, 0);
    drive_core(tbl[0], -100);
    rsp_ready = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hls_macc_drv.md
HLS_MACC_DRV -- requirements
Module: hls_macc_drv

Interface
REQ-001 The block SHALL have a single clock, ap_clk; reset is ap_rst, synchronous and active-high.
REQ-002 The block SHALL have parameter TMO_CYC, default 1024, the maximum cycles from the first ap_start to ap_done before abort (range 2..65535).
REQ-003 The block SHALL have parameter DW, default 32, the operand and result width.
REQ-004 Ports SHALL be as follows:
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous active-high reset
- cmd_valid  in  1  host operand set valid
- cmd_ready  out  1  driver accepts operand set
- cmd_i1, cmd_i2, cmd_i3, cmd_i4, cmd_i6  in  DW each  host operands
- core_ap_start  out  1  ap_ctrl_hs start to core
- core_ap_ready  in  1  core consumed inputs
- core_ap_done  in  1  core finished
- core_ap_idle  in  1  core idle
- core_i1, core_i2, core_i3, core_i4, core_i6  out  DW each  operands to core
- core_o1, core_o2  in  DW each  core results
- core_o1_ap_vld, core_o2_ap_vld  in  1 each  result valid strobes
- rsp_valid  out  1  result available
- rsp_ready  in  1  host takes result
- rsp_o1, rsp_o2  out  DW each  captured results
- rsp_o1_vld, rsp_o2_vld  out  1 each  the result was strobed during this operation
- rsp_err  out  1  timeout abort
- op_cnt  out  16  completed operations, wraps at 16'hFFFF to 0

Function
REQ-005 The FSM SHALL have four states, IDLE, START, WAIT, RESP, with exactly one state active at any time.
REQ-006 IDLE behaviour: cmd_ready = core_ap_idle; on cmd_valid&cmd_ready the driver SHALL latch all five operands, clear the capture flags and timeout counter, and enter START.
REQ-007 START behaviour: core_ap_start SHALL be 1 (registered, first asserted the cycle after acceptance) and core_i* SHALL hold the latched operands; the driver SHALL stay in START until core_ap_ready=1, then enter WAIT, or RESP if core_ap_done=1 in the same cycle.
REQ-008 core_i* SHALL remain stable from START through RESP; operands SHALL change only on a new acceptance.
REQ-009 In START and WAIT, each cycle core_o1_ap_vld=1 SHALL register core_o1 into rsp_o1 and set rsp_o1_vld; core_o2 SHALL be handled identically; a later strobe SHALL overwrite the earlier value (last value wins).
REQ-010 WAIT behaviour: core_ap_start=0; on core_ap_done=1 the driver SHALL enter RESP with rsp_err=0; strobes coincident with done SHALL be captured.
REQ-011 The timeout counter SHALL increment every cycle in START and WAIT; when it reaches TMO_CYC-1 without done, the driver SHALL enter RESP with rsp_err=1 and deassert core_ap_start. Done in that same cycle SHALL take priority (err=0).
REQ-012 RESP behaviour: rsp_valid SHALL be 1 and rsp_* stable until rsp_ready=1; on that cycle the driver SHALL return to IDLE and increment op_cnt (including errored operations).
REQ-013 Latency: acceptance at cycle 0; core_ap_start at cycle 1; core_ap_done at cycle k gives rsp_valid at k+1. Minimum accept-to-rsp_valid latency SHALL be 2 cycles.
REQ-014 cmd_ready SHALL be 0 in START, WAIT and RESP; there SHALL be no command buffering.
REQ-015 Any core_ap_done, ready or vld in IDLE or RESP SHALL be ignored.

Reset
REQ-016 While ap_rst=1, the FSM SHALL be IDLE and all outputs SHALL be 0 (core_ap_start, rsp_valid, rsp_*, op_cnt, core_i*, counters); cmd_ready follows core_ap_idle once released.
REQ-017 Reset mid-operation SHALL abandon the operation with no response, and SHALL deassert core_ap_start on the next edge.

Structure
REQ-018 Package hls_macc_pkg SHALL hold the state enum, DW default, and the op_cnt width constant (16).
REQ-019 The timeout counter SHALL be one sub-module, hls_tmo_cnt (clear, enable, terminal-count output); everything else SHALL be flat.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Core model (ready after 1 cycle, done plus both vld at 3 cycles) with i1=3, i2=4 -> rsp_o1/o2 match the model, rsp_valid 4 cycles after acceptance, err=0, op_cnt=1.
- Core never asserts done with TMO_CYC=8 -> rsp_valid with rsp_err=1 at cycle 9, start low, flags=0.
- rsp_ready held 0 for 5 cycles -> rsp stable, cmd_ready=0, core done pulses ignored.
- Two o1 strobes (0x11 then 0x22) -> rsp_o1=0x22, rsp_o2_vld=0 when no o2 strobe.
- ap_rst asserted in WAIT -> next cycle all outputs 0 and IDLE; a new command completes normally.
- 65536 back-to-back operations -> op_cnt wraps to 0.
